// File: rtl/bias_trim_pkg.sv
// Shared types and constants for the PMOS bias trim SAR calibration block.
// BIAS_TRIM_AVG_EN selects 3-sample majority voting in the SAMPLE state.
package bias_trim_pkg;

   localparam int BIAS_TRIM_CODE_W   = 6;
   localparam int BIAS_TRIM_SETTLE_W = 8;

`ifdef BIAS_TRIM_AVG_EN
   localparam int SAMPLE_CYC = 3;
`else
   localparam int SAMPLE_CYC = 1;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } bias_trim_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/bias_trim_sync.sv
// Two-flop synchronizer for the asynchronous comparator output.
module bias_trim_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/bias_trim_sar.sv
// Successive-approximation trim search for the PMOS bias DAC, MSB first.
// Optional BIAS_TRIM_AVG_EN: majority of 3 comparator samples per bit decision.
module bias_trim_sar
   import bias_trim_pkg::*;
#(
   parameter int CODE_W   = BIAS_TRIM_CODE_W,
   parameter int SETTLE_W = BIAS_TRIM_SETTLE_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                cmp_in,
   input  logic [SETTLE_W-1:0] settle_cyc,
   output logic [CODE_W-1:0]   trim_code,
   output logic                busy,
   output logic                done,
   output logic                cal_ok,
   output bias_trim_state_e    dbg_state
);

   localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam logic [CODE_W-1:0] MID_CODE = CODE_W'(1) << (CODE_W - 1);
   localparam logic [1:0] SMP_LAST = 2'(SAMPLE_CYC - 1);

   // Protocol: start is a level sampled only in IDLE (no queuing); done is a
   // one-cycle pulse in DONE, and busy covers every non-IDLE cycle.
   bias_trim_state_e    state_q, state_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;
   logic [1:0]          smp_cnt_q, smp_cnt_d;
   logic                cal_ok_q, cal_ok_d;
   logic                cmp_s;
   logic                bit_hi;
   logic [IDX_W-1:0]    idx_m1;
   logic [SETTLE_W-1:0] settle_load;

   bias_trim_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (cmp_in),
      .q_o   (cmp_s)
   );

   assign settle_load = (settle_cyc == '0) ? SETTLE_W'(1) : settle_cyc;
   assign idx_m1      = idx_q - IDX_W'(1);

`ifdef BIAS_TRIM_AVG_EN
   logic [1:0] samp_q, samp_d;

   always_comb begin
      samp_d = samp_q;
      if (state_q == SAMPLE && smp_cnt_q != SMP_LAST) samp_d = {samp_q[0], cmp_s};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) samp_q <= '0;
      else        samp_q <= samp_d;
   end

   assign bit_hi = maj3(samp_q[1], samp_q[0], cmp_s);
`else
   assign bit_hi = cmp_s;
`endif

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      smp_cnt_d = smp_cnt_q;
      cal_ok_d  = cal_ok_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               code_d  = MID_CODE;
               idx_d   = IDX_W'(CODE_W - 1);
               cnt_d   = settle_load;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q <= SETTLE_W'(1)) begin
               smp_cnt_d = '0;
               state_d   = SAMPLE;
            end else begin
               cnt_d = cnt_q - SETTLE_W'(1);
            end
         end
         SAMPLE: begin
            if (smp_cnt_q != SMP_LAST) begin
               smp_cnt_d = smp_cnt_q + 2'd1;
            end else begin
               // Comparator high means current too large: drop this bit.
               if (bit_hi) code_d[idx_q] = 1'b0;
               if (idx_q != '0) begin
                  code_d[idx_m1] = 1'b1;
                  idx_d          = idx_m1;
                  cnt_d          = settle_load;
                  state_d        = SETTLE;
               end else begin
                  cal_ok_d = (code_d != '0) && (code_d != '1);
                  state_d  = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         code_q    <= MID_CODE;
         idx_q     <= '0;
         cnt_q     <= '0;
         smp_cnt_q <= '0;
         cal_ok_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         smp_cnt_q <= smp_cnt_d;
         cal_ok_q  <= cal_ok_d;
      end
   end

   assign trim_code = code_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign cal_ok    = cal_ok_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_bias_trim_sar.sv
// Directed bench for bias_trim_sar with a threshold comparator model.
module tb_bias_trim_sar;
   import bias_trim_pkg::*;

`ifdef BIAS_TRIM_AVG_EN
   localparam int SAMP = 3;
`else
   localparam int SAMP = 1;
`endif

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             cmp_in;
   logic [7:0]       settle_cyc;
   logic [5:0]       trim_code;
   logic             busy;
   logic             done;
   logic             cal_ok;
   bias_trim_state_e dbg_state;

   int   cmp_t;
   logic force_en;
   logic force_val;
   logic inv;
   int   checks;
   int   errors;

   typedef struct {
      int   t;
      int   settle;
      logic fen;
      logic fval;
      int   exp_code;
      logic exp_ok;
      int   exp_lat;
      logic trace;
   } vec_t;

   vec_t vecs[8];
   int   exp_trace[6];

   bias_trim_sar #(.CODE_W(6), .SETTLE_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cmp_in     (cmp_in),
      .settle_cyc (settle_cyc),
      .trim_code  (trim_code),
      .busy       (busy),
      .done       (done),
      .cal_ok     (cal_ok),
      .dbg_state  (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb cmp_in = inv ^ (force_en ? force_val : (int'(trim_code) > cmp_t));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic run_cal(input string tag, input vec_t v, input logic inject);
      int          n;
      logic [5:0]  prev;
      int          trials[$];
      bias_trim_state_e pst;
      cmp_t      = v.t;
      force_en   = v.fen;
      force_val  = v.fval;
      settle_cyc = 8'(v.settle);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      chk({tag, "_busy_start"}, int'(busy), 1);
      chk({tag, "_mid_start"}, int'(trim_code), 32);
      prev = trim_code;
      trials.push_back(int'(prev));
      pst = dbg_state;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
         if (inject) inv = (dbg_state == SAMPLE) && (pst != SAMPLE);
         pst = dbg_state;
         if (trim_code != prev) begin
            prev = trim_code;
            trials.push_back(int'(prev));
         end
      end
      inv = 1'b0;
      chk({tag, "_latency"}, n, v.exp_lat);
      chk({tag, "_code"}, int'(trim_code), v.exp_code);
      chk({tag, "_cal_ok"}, int'(cal_ok), int'(v.exp_ok));
      @(negedge clk);
      chk({tag, "_busy_after"}, int'(busy), 0);
      chk({tag, "_done_pulse"}, int'(done), 0);
      repeat (3) @(negedge clk);
      chk({tag, "_code_hold"}, int'(trim_code), v.exp_code);
      chk({tag, "_ok_hold"}, int'(cal_ok), int'(v.exp_ok));
      if (v.trace) begin
         chk({tag, "_trial_cnt"}, trials.size(), 6);
         for (int i = 0; i < 6 && i < trials.size(); i++)
            chk($sformatf("%s_trial%0d", tag, i), trials[i], exp_trace[i]);
      end
   endtask

   initial begin
      int   done_cnt;
      vec_t v6;
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      start = 1'b0;
      inv = 1'b0;
      force_en = 1'b0;
      force_val = 1'b0;
      cmp_t = 37;
      settle_cyc = 8'd4;

      exp_trace = '{32, 48, 40, 36, 38, 37};
      vecs[0] = '{37, 4, 1'b0, 1'b0, 37, 1'b1, 6 * (4 + SAMP) + 1, 1'b1};
      vecs[1] = '{63, 4, 1'b0, 1'b0, 63, 1'b0, 6 * (4 + SAMP) + 1, 1'b0};
      vecs[2] = '{0,  4, 1'b0, 1'b0, 0,  1'b0, 6 * (4 + SAMP) + 1, 1'b0};
      vecs[3] = '{0,  0, 1'b1, 1'b0, 63, 1'b0, 6 * (1 + SAMP) + 1, 1'b0};
      vecs[4] = '{0,  0, 1'b1, 1'b1, 0,  1'b0, 6 * (1 + SAMP) + 1, 1'b0};
      vecs[5] = '{20, 3, 1'b0, 1'b0, 20, 1'b1, 6 * (3 + SAMP) + 1, 1'b0};
      vecs[6] = '{1,  2, 1'b0, 1'b0, 1,  1'b1, 6 * (2 + SAMP) + 1, 1'b0};
      vecs[7] = '{62, 5, 1'b0, 1'b0, 62, 1'b1, 6 * (5 + SAMP) + 1, 1'b0};

      // Reset state, held through 100 idle cycles with no start.
      repeat (3) @(negedge clk);
      chk("rst_code", int'(trim_code), 32);
      chk("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         chk("idle_code", int'(trim_code), 32);
         chk("idle_busy", int'(busy), 0);
         chk("idle_done", int'(done), 0);
         chk("idle_cal_ok", int'(cal_ok), 0);
      end

      for (int i = 0; i < 8; i++) run_cal($sformatf("vec%0d", i), vecs[i], 1'b0);

`ifdef BIAS_TRIM_AVG_EN
      v6 = '{37, 4, 1'b0, 1'b0, 37, 1'b1, 43, 1'b0};
      run_cal("avg_glitch", v6, 1'b1);
`endif

      // Start while busy is ignored, then an async reset aborts the run.
      cmp_t = 37;
      force_en = 1'b0;
      settle_cyc = 8'd4;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("busy_start_code", int'(trim_code), 48);
      chk("busy_start_state", int'(dbg_state), int'(SETTLE));
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_code", int'(trim_code), 32);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_cal_ok", int'(cal_ok), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      chk("abort_no_done", done_cnt, 0);
      chk("abort_idle_code", int'(trim_code), 32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
